// File: rtl/pipe_is_tracker.sv
// Instruction-history pipeline (ID -> EX -> MEM -> WB) that feeds the hazard/forwarding unit.
// Optional bubble counter enabled by defining BUBBLE_CNT_EN (adds out_BCNT).
module pipe_is_tracker #(
   parameter int unsigned IS_W  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic             in_CLK,
   input  logic             in_RST,
   input  logic             in_EN,
   input  logic [IS_W-1:0]  in_IS,
   input  logic             in_WE,
   input  logic             in_DECLR,
   input  logic             in_EXCLR,
   input  logic             in_CNTCLR,
   output logic [IS_W-1:0]  out_PIS,
   output logic [IS_W-1:0]  out_PPIS,
   output logic [IS_W-1:0]  out_PPPIS,
   output logic             out_PWE,
   output logic             out_PPWE,
   output logic             out_PPPWE,
   output logic             out_RETIRE,
   output logic [CNT_W-1:0] out_ICNT
`ifdef BUBBLE_CNT_EN
   ,
   output logic [CNT_W-1:0] out_BCNT
`endif
);

   localparam int unsigned OPC_W   = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned OPC_LSB = 26;
   localparam int unsigned RT_LSB  = 16;
   localparam int unsigned RD_LSB  = 11;

   localparam logic [OPC_W-1:0] OPC_RTYPE = OPC_W'(0);
   localparam logic [OPC_W-1:0] OPC_JAL   = OPC_W'(3);
   localparam logic [REG_W-1:0] REG_RA    = REG_W'(31);

   logic [OPC_W-1:0] opcode_c;
   logic [REG_W-1:0] dest_c;
   logic             eff_we_c;
   logic             bubble_c;
   logic             retire_c;

   // Destination-register decode; writes aimed at $0 are dropped.
   always_comb begin
      opcode_c = in_IS[OPC_LSB +: OPC_W];
      dest_c   = in_IS[RT_LSB +: REG_W];
      if (opcode_c == OPC_RTYPE) begin
         dest_c = in_IS[RD_LSB +: REG_W];
      end else if (opcode_c == OPC_JAL) begin
         dest_c = REG_RA;
      end
      eff_we_c = in_WE & (dest_c != '0);
      bubble_c = in_DECLR | in_EXCLR;
      retire_c = (out_PPPIS != '0);
   end

   // History shift register; bubbles enter only at the EX slot.
   always_ff @(posedge in_CLK or negedge in_RST) begin
      if (!in_RST) begin
         out_PIS    <= '0;
         out_PPIS   <= '0;
         out_PPPIS  <= '0;
         out_PWE    <= 1'b0;
         out_PPWE   <= 1'b0;
         out_PPPWE  <= 1'b0;
         out_RETIRE <= 1'b0;
      end else if (in_EN) begin
         out_PPPIS  <= out_PPIS;
         out_PPPWE  <= out_PPWE;
         out_PPIS   <= out_PIS;
         out_PPWE   <= out_PWE;
         out_PIS    <= bubble_c ? '0 : in_IS;
         out_PWE    <= bubble_c ? 1'b0 : eff_we_c;
         out_RETIRE <= retire_c;
      end
   end

   // Retired-instruction counter; clear wins over increment.
   always_ff @(posedge in_CLK or negedge in_RST) begin
      if (!in_RST) begin
         out_ICNT <= '0;
      end else if (in_EN) begin
         if (in_CNTCLR) begin
            out_ICNT <= '0;
         end else if (retire_c) begin
            out_ICNT <= out_ICNT + CNT_W'(1);
         end
      end
   end

`ifdef BUBBLE_CNT_EN
   // Bubble counter; simultaneous DECLR/EXCLR count as one bubble.
   always_ff @(posedge in_CLK or negedge in_RST) begin
      if (!in_RST) begin
         out_BCNT <= '0;
      end else if (in_EN) begin
         if (in_CNTCLR) begin
            out_BCNT <= '0;
         end else if (bubble_c) begin
            out_BCNT <= out_BCNT + CNT_W'(1);
         end
      end
   end
`else
   // No bubble counter in this build.
`endif

endmodule
